// File: rtl/bram18k_ctrl_pkg.sv
// Shared defaults and FSM encoding for the BRAM 18K simple-dual-port controller.
package bram18k_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 18;
  localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the loser after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic prio_b;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_b ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // req arrives already qualified, so any grant is an accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b <= 1'b0;
    end else if (|grant) begin
      prio_b <= grant[0];
    end
  end

endmodule

// File: rtl/bram18k_sdp_arbiter.sv
// Two-requester front end for one RAM_18K_X2_BLK half: sweeps INIT_VALUE into the
// array after reset/clear, then arbitrates read/write commands round-robin.
module bram18k_sdp_arbiter
  import bram18k_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock0,
  input  logic                  RESET_ni,
  input  logic                  clear_i,
  output logic                  init_done_o,
  output state_t                dbg_state_o,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_rvalid_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_rvalid_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  ram_wen_o,
  output logic                  ram_ren_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  // Handshake: a command transfers in any cycle where valid and ready are both high;
  // ready is combinational, never high outside RUN, and drops while clear_i is high.
  // Read data is a one-cycle rvalid strobe with no backpressure.

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  run_ok;
  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  accept;
  logic                  sel_b;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rd_v1;
  logic                  rd_t1;

  assign run_ok = (state == ST_RUN) && init_done_o && !clear_i;
  assign req    = {b_valid_i, a_valid_i} & {2{run_ok}};

  rr_arb2 u_arb (
    .clk   (clock0),
    .rst_n (RESET_ni),
    .req   (req),
    .grant (grant)
  );

  assign a_ready_o = grant[0];
  assign b_ready_o = grant[1];
  assign accept    = |grant;
  assign sel_b     = grant[1];
  assign cmd_we    = sel_b ? b_we_i    : a_we_i;
  assign cmd_addr  = sel_b ? b_addr_i  : a_addr_i;
  assign cmd_wdata = sel_b ? b_wdata_i : a_wdata_i;

  assign dbg_state_o = state;

  // RAM data is only meaningful alongside the strobe; zero otherwise keeps reset clean.
  assign a_rdata_o = a_rvalid_o ? ram_rdata_i : '0;
  assign b_rdata_o = b_rvalid_o ? ram_rdata_i : '0;

  always_ff @(posedge clock0 or negedge RESET_ni) begin
    if (!RESET_ni) begin
      state       <= ST_INIT;
      cnt         <= '0;
      init_done_o <= 1'b0;
      ram_wen_o   <= 1'b0;
      ram_ren_o   <= 1'b0;
      ram_waddr_o <= '0;
      ram_raddr_o <= '0;
      ram_wdata_o <= '0;
      rd_v1       <= 1'b0;
      rd_t1       <= 1'b0;
      a_rvalid_o  <= 1'b0;
      b_rvalid_o  <= 1'b0;
    end else begin
      ram_wen_o   <= 1'b0;
      ram_ren_o   <= 1'b0;
      init_done_o <= (state == ST_RUN) && !clear_i;

      // Tag pipeline keeps running through clear so issued reads still return.
      rd_v1      <= accept && !cmd_we;
      rd_t1      <= sel_b;
      a_rvalid_o <= rd_v1 && !rd_t1;
      b_rvalid_o <= rd_v1 && rd_t1;

      case (state)
        ST_INIT: begin
          if (clear_i) begin
            cnt <= '0;
          end else begin
            ram_wen_o   <= 1'b1;
            ram_waddr_o <= cnt;
            ram_wdata_o <= INIT_VALUE;
            if (cnt == LAST_ADDR) begin
              state <= ST_RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (clear_i) begin
            state <= ST_INIT;
            cnt   <= '0;
          end else if (accept) begin
            if (cmd_we) begin
              ram_wen_o   <= 1'b1;
              ram_waddr_o <= cmd_addr;
              ram_wdata_o <= cmd_wdata;
            end else begin
              ram_ren_o   <= 1'b1;
              ram_raddr_o <= cmd_addr;
            end
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram18k_sdp_arbiter.sv
// Directed bench: init sweep, write/read forwarding, round-robin, clear and reset behaviour.
module tb_bram18k_sdp_arbiter;
  import bram18k_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 18;

  // clock / reset
  logic clock0 = 1'b0;
  always #5 clock0 = ~clock0;
  logic RESET_ni;
  logic clear_i;

  // main instance signals
  logic          init_done_o;
  state_t        dbg_state_o;
  logic          a_valid_i, a_ready_o, a_we_i, a_rvalid_o;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i, a_rdata_o;
  logic          b_valid_i, b_ready_o, b_we_i, b_rvalid_o;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_wdata_i, b_rdata_o;
  logic          ram_wen_o, ram_ren_o;
  logic [AW-1:0] ram_waddr_o, ram_raddr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i = '0;

  // second instance with a non-zero fill word
  logic          v_init_done_o;
  state_t        v_dbg_state_o;
  logic          v_a_valid_i, v_a_ready_o, v_a_rvalid_o;
  logic [AW-1:0] v_a_addr_i;
  logic [DW-1:0] v_a_rdata_o;
  logic          v_b_ready_o, v_b_rvalid_o;
  logic [DW-1:0] v_b_rdata_o;
  logic          v_ram_wen_o, v_ram_ren_o;
  logic [AW-1:0] v_ram_waddr_o, v_ram_raddr_o;
  logic [DW-1:0] v_ram_wdata_o;
  logic [DW-1:0] v_ram_rdata_i = '0;
  logic          v_zero1 = 1'b0;
  logic [AW-1:0] v_zero_a = '0;
  logic [DW-1:0] v_zero_d = '0;

  bram18k_sdp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(18'h00000)) dut (
    .clock0(clock0), .RESET_ni(RESET_ni), .clear_i(clear_i),
    .init_done_o(init_done_o), .dbg_state_o(dbg_state_o),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_we_i(a_we_i), .a_addr_i(a_addr_i),
    .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_we_i(b_we_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
    .ram_wen_o(ram_wen_o), .ram_ren_o(ram_ren_o), .ram_waddr_o(ram_waddr_o),
    .ram_raddr_o(ram_raddr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  bram18k_sdp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(18'h00155)) dut_iv (
    .clock0(clock0), .RESET_ni(RESET_ni), .clear_i(v_zero1),
    .init_done_o(v_init_done_o), .dbg_state_o(v_dbg_state_o),
    .a_valid_i(v_a_valid_i), .a_ready_o(v_a_ready_o), .a_we_i(v_zero1), .a_addr_i(v_a_addr_i),
    .a_wdata_i(v_zero_d), .a_rvalid_o(v_a_rvalid_o), .a_rdata_o(v_a_rdata_o),
    .b_valid_i(v_zero1), .b_ready_o(v_b_ready_o), .b_we_i(v_zero1), .b_addr_i(v_zero_a),
    .b_wdata_i(v_zero_d), .b_rvalid_o(v_b_rvalid_o), .b_rdata_o(v_b_rdata_o),
    .ram_wen_o(v_ram_wen_o), .ram_ren_o(v_ram_ren_o), .ram_waddr_o(v_ram_waddr_o),
    .ram_raddr_o(v_ram_raddr_o), .ram_wdata_o(v_ram_wdata_o), .ram_rdata_i(v_ram_rdata_i)
  );

  // synchronous RAM models, one-cycle read latency
  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] v_mem [0:(1<<AW)-1];

  always @(posedge clock0) begin
    if (ram_wen_o) mem[ram_waddr_o] <= ram_wdata_o;
    if (ram_ren_o) ram_rdata_i <= mem[ram_raddr_o];
    if (v_ram_wen_o) v_mem[v_ram_waddr_o] <= v_ram_wdata_o;
    if (v_ram_ren_o) v_ram_rdata_i <= v_mem[v_ram_raddr_o];
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  // Entered just after the edge that registers the write to address 0.
  task automatic init_sweep(input string tag);
    int bad;
    bad = 0;
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    a_we_i    = 1'b0;
    b_we_i    = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (ram_wen_o !== 1'b1 || ram_waddr_o !== i[AW-1:0] || ram_wdata_o !== 18'h0 ||
          ram_ren_o !== 1'b0 || a_ready_o !== 1'b0 || b_ready_o !== 1'b0 ||
          init_done_o !== 1'b0)
        bad++;
      step();
    end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    chk({tag, "_bad_cycles"}, 32'(bad), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done_o), 32'd1);
    chk({tag, "_wen_after"}, 32'(ram_wen_o), 32'd0);
    chk({tag, "_state_run"}, 32'(dbg_state_o), 32'(ST_RUN));
  endtask

  task automatic do_write(input logic sel_b, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (sel_b) begin
      b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = addr; b_wdata_i = data;
    end else begin
      a_valid_i = 1'b1; a_we_i = 1'b1; a_addr_i = addr; a_wdata_i = data;
    end
    #1;
    chk("wr_ready", 32'(sel_b ? b_ready_o : a_ready_o), 32'd1);
    step();
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
  endtask

  initial begin
    logic exp_b;
    RESET_ni  = 1'b0;
    clear_i   = 1'b0;
    a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0;
    b_valid_i = 1'b0; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0;
    v_a_valid_i = 1'b0; v_a_addr_i = '0;

    repeat (3) step();
    chk("rst_wen", 32'(ram_wen_o), 32'd0);
    chk("rst_waddr", 32'(ram_waddr_o), 32'd0);
    chk("rst_init_done", 32'(init_done_o), 32'd0);
    chk("rst_a_ready", 32'(a_ready_o), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid_o), 32'd0);
    chk("rst_a_rdata", 32'(a_rdata_o), 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'(ST_INIT));
    a_valid_i = 1'b0;

    // release, then 1024-write sweep with init_done one edge after the last write
    @(negedge clock0);
    RESET_ni = 1'b1;
    step();
    init_sweep("init0");
    chk("iv_init_done", 32'(v_init_done_o), 32'd1);

    // never-written top address reads back the fill word
    v_a_valid_i = 1'b1; v_a_addr_i = 10'd1023;
    #1;
    chk("iv_ready", 32'(v_a_ready_o), 32'd1);
    step();
    v_a_valid_i = 1'b0;
    step();
    chk("iv_rvalid", 32'(v_a_rvalid_o), 32'd1);
    chk("iv_rdata", 32'(v_a_rdata_o), 32'h155);

    // write then immediate read of the same address
    a_valid_i = 1'b1; a_we_i = 1'b1; a_addr_i = 10'd5; a_wdata_i = 18'h2ABCD;
    #1;
    chk("wr5_a_ready", 32'(a_ready_o), 32'd1);
    chk("wr5_b_ready", 32'(b_ready_o), 32'd0);
    step();
    chk("wr5_wen", 32'(ram_wen_o), 32'd1);
    chk("wr5_waddr", 32'(ram_waddr_o), 32'd5);
    chk("wr5_wdata", 32'(ram_wdata_o), 32'h2ABCD);
    a_we_i = 1'b0;
    #1;
    chk("rd5_ready", 32'(a_ready_o), 32'd1);
    step();
    chk("rd5_ren", 32'(ram_ren_o), 32'd1);
    chk("rd5_raddr", 32'(ram_raddr_o), 32'd5);
    chk("rd5_wen", 32'(ram_wen_o), 32'd0);
    a_valid_i = 1'b0;
    step();
    chk("rd5_rvalid", 32'(a_rvalid_o), 32'd1);
    chk("rd5_rdata", 32'(a_rdata_o), 32'h2ABCD);
    chk("rd5_b_rvalid", 32'(b_rvalid_o), 32'd0);
    step();
    chk("rd5_rvalid_drop", 32'(a_rvalid_o), 32'd0);

    // preload; last grant goes to B so A holds priority next
    do_write(1'b1, 10'd20, 18'h11111);
    do_write(1'b0, 10'd21, 18'h22222);
    do_write(1'b1, 10'd22, 18'h33333);

    // both requesters read continuously for four cycles
    a_we_i = 1'b0; b_we_i = 1'b0; a_addr_i = 10'd20; b_addr_i = 10'd21;
    for (int k = 0; k < 6; k++) begin
      a_valid_i = (k < 4);
      b_valid_i = (k < 4);
      #1;
      if (k < 4) begin
        chk("rr_a_ready", 32'(a_ready_o), 32'((k % 2) == 0));
        chk("rr_b_ready", 32'(b_ready_o), 32'((k % 2) == 1));
      end
      if (k >= 2) begin
        exp_b = ((k - 2) % 2) == 1;
        chk("rr_a_rvalid", 32'(a_rvalid_o), 32'(!exp_b));
        chk("rr_b_rvalid", 32'(b_rvalid_o), 32'(exp_b));
        chk("rr_rdata", 32'(exp_b ? b_rdata_o : a_rdata_o), exp_b ? 32'h22222 : 32'h11111);
      end
      step();
    end

    // B read, clear next cycle: read still returns, new command refused, sweep restarts
    b_valid_i = 1'b1; b_we_i = 1'b0; b_addr_i = 10'd21;
    #1;
    chk("clr_b_ready", 32'(b_ready_o), 32'd1);
    step();
    b_valid_i = 1'b0;
    clear_i   = 1'b1;
    a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'd20;
    #1;
    chk("clr_a_ready", 32'(a_ready_o), 32'd0);
    chk("clr_b_ready_low", 32'(b_ready_o), 32'd0);
    chk("clr_ren", 32'(ram_ren_o), 32'd1);
    step();
    clear_i   = 1'b0;
    a_valid_i = 1'b0;
    chk("clr_b_rvalid", 32'(b_rvalid_o), 32'd1);
    chk("clr_b_rdata", 32'(b_rdata_o), 32'h22222);
    chk("clr_no_ren", 32'(ram_ren_o), 32'd0);
    chk("clr_no_wen", 32'(ram_wen_o), 32'd0);
    chk("clr_init_done", 32'(init_done_o), 32'd0);
    step();
    init_sweep("clr_sweep");

    // restart sweep, reset it at address 300
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (301) step();
    chk("mid_waddr", 32'(ram_waddr_o), 32'd300);
    chk("mid_wen", 32'(ram_wen_o), 32'd1);
    RESET_ni = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(ram_wen_o), 32'd0);
    chk("mid_rst_waddr", 32'(ram_waddr_o), 32'd0);
    chk("mid_rst_wdata", 32'(ram_wdata_o), 32'd0);
    chk("mid_rst_state", 32'(dbg_state_o), 32'(ST_INIT));
    @(posedge clock0);
    @(negedge clock0);
    RESET_ni = 1'b1;
    step();
    init_sweep("rst_sweep");

    // read in flight when reset hits never produces rvalid
    a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'd5;
    #1;
    chk("flight_ready", 32'(a_ready_o), 32'd1);
    step();
    a_valid_i = 1'b0;
    RESET_ni  = 1'b0;
    #1;
    chk("flight_ren", 32'(ram_ren_o), 32'd0);
    step();
    chk("flight_rvalid", 32'(a_rvalid_o), 32'd0);
    step();
    chk("flight_rvalid2", 32'(a_rvalid_o), 32'd0);
    RESET_ni = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
